// File: rtl/shift_pkg.sv
// shift_pkg: shared constants, request struct and helpers for the shift
// sequencing controller and its 3-bit barrel core.
//   DATA_W   : datapath width (fixed at 8)
//   MAX_STEP : largest amount the core applies in one pass
//   OP_*     : operation codes on req_op
//   ST_*     : controller state encoding
package shift_pkg;

  localparam int DATA_W = 8;
  localparam logic [2:0] MAX_STEP = 3'd7;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic [1:0]        op;
    logic [7:0]        amt;
    logic [DATA_W-1:0] data;
  } shift_req_t;

  // Bit reversal: turns a left shift into a right shift and back.
  function automatic logic [DATA_W-1:0] rev(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] o;
    for (int i = 0; i < DATA_W; i++) o[i] = d[DATA_W-1-i];
    return o;
  endfunction

  // Effective amount: rotates wrap modulo 8, shifts saturate at 8 since
  // anything past that already empties (or sign-fills) the whole word.
  function automatic logic [3:0] eff_amt(input logic [1:0] op, input logic [7:0] amt);
    if (op == OP_ROR)       return {1'b0, amt[2:0]};
    else if (amt >= 8'd8)   return 4'd8;
    else                    return amt[3:0];
  endfunction

endpackage

// File: rtl/shift_core8.sv
// shift_core8: combinational 8-bit right barrel shifter, three stages of
// 1/2/4 bit positions selected by amt[0..2].
//   arith : fill vacated bits with the MSB (ignored when rot=1)
//   rot   : rotate, vacated bits take the bits shifted out
//   amt   : shift amount 0..7
//   data  : operand
//   out   : shifted result
import shift_pkg::*;

module shift_core8 (
  input  logic              arith,
  input  logic              rot,
  input  logic [2:0]        amt,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] out
);

  logic [3:0][DATA_W-1:0] st;

  assign st[0] = data;

  for (genvar i = 0; i < 3; i++) begin : g_stage
    localparam int SH = 1 << i;
    logic [SH-1:0] fill;
    // Sign comes from the current stage input; earlier stages already
    // replicated the MSB so it is still the original sign bit.
    assign fill = rot ? st[i][SH-1:0] : {SH{arith & st[i][DATA_W-1]}};
    assign st[i+1] = amt[i] ? {fill, st[i][DATA_W-1:SH]} : st[i];
  end

  assign out = st[3];

endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequences an 8-bit shift/rotate request through the
// 3-bit shift_core8, one pass per RUN cycle (two passes for amount 8).
// Left shifts run as right shifts on the bit-reversed operand.
//   clk, reset      : clock, synchronous active-low reset
//   req_valid/ready : request handshake (ready only in IDLE)
//   req_op/amt/data : operation, unsigned amount, operand
//   res_valid/ready : result handshake; res_data held while res_valid
//   busy            : request in flight (RUN or DONE)
import shift_pkg::*;

module shift_seq_ctrl (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [7:0]        req_amt,
  input  logic [DATA_W-1:0] req_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              busy
);

  logic [1:0]        state;
  logic [1:0]        op;
  logic [DATA_W-1:0] w;
  logic [3:0]        r;
  logic [2:0]        step;
  logic [3:0]        r_next;
  logic [DATA_W-1:0] core_out;
  shift_req_t        req;

  assign req = '{op: req_op, amt: req_amt, data: req_data};

  // Largest pass the core can take; an amount of 8 becomes 7 then 1.
  assign step   = (r > {1'b0, MAX_STEP}) ? MAX_STEP : r[2:0];
  assign r_next = r - {1'b0, step};

  shift_core8 u_core (
    .arith (op == OP_SRA),
    .rot   (op == OP_ROR),
    .amt   (step),
    .data  (w),
    .out   (core_out)
  );

  // Reset is folded in so ready is low for the whole reset interval.
  assign req_ready = (state == ST_IDLE) && reset;
  assign res_valid = (state == ST_DONE);
  assign busy      = (state == ST_RUN) || (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      op       <= OP_SLL;
      w        <= '0;
      r        <= '0;
      res_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            state <= ST_RUN;
            op    <= req.op;
            w     <= (req.op == OP_SLL) ? rev(req.data) : req.data;
            r     <= eff_amt(req.op, req.amt);
          end
        end
        ST_RUN: begin
          // Amount 0 still makes one pass with step 0.
          w <= core_out;
          r <= r_next;
          if (r_next == 4'd0) begin
            state    <= ST_DONE;
            res_data <= (op == OP_SLL) ? rev(core_out) : core_out;
          end
        end
        ST_DONE: begin
          // Returning to IDLE takes this edge, so no accept can coincide
          // with a consume.
          if (res_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_amt;
  logic [7:0] req_data;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int popped = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  shift_seq_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_amt   (req_amt),
    .req_data  (req_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy)
  );

  function automatic logic [7:0] model(input logic [1:0] op, input logic [7:0] amt,
                                       input logic [7:0] d);
    logic [15:0] dd;
    logic [7:0]  o;
    case (op)
      2'b00: o = (amt >= 8) ? 8'h00 : 8'(d << amt[2:0]);
      2'b01: o = (amt >= 8) ? 8'h00 : 8'(d >> amt[2:0]);
      2'b10: o = (amt >= 8) ? {8{d[7]}} : 8'($signed(d) >>> amt[2:0]);
      default: begin
        dd = {d, d} >> amt[2:0];
        o  = dd[7:0];
      end
    endcase
    return o;
  endfunction

  // Scoreboard: a result is consumed on an edge with res_valid & res_ready;
  // values are stable at the preceding falling edge.
  always @(negedge clk) begin
    if (reset && res_valid && res_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_unexpected: got %02h with nothing expected", res_data);
      end else begin
        if (res_data !== exp_q[0]) begin
          errors++;
          $display("FAIL scoreboard_data: got %02h expected %02h", res_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      popped++;
    end
  end

  // Drive a request, push its expected result, return #1 after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [7:0] amt, input logic [7:0] d);
    int n = 0;
    req_op = op; req_amt = amt; req_data = d; req_valid = 1'b1;
    exp_q.push_back(model(op, amt, d));
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 200);
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready=%0b expected 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (busy || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: busy=%0b pending=%0d expected 0/0", busy, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b0; res_ready = 1'b0;
    req_op = 2'b00; req_amt = 8'h00; req_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, res_valid, busy, res_data} !== 11'h0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%0b vld=%0b busy=%0b data=%02h expected all 0",
               req_ready, res_valid, busy, res_data);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %0b expected 1", req_ready);
    end
  endtask

  task automatic test_srl();
    res_ready = 1'b1;
    issue(2'b01, 8'd3, 8'h51);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL srl_run: vld=%0b busy=%0b expected 0/1", res_valid, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b1 || res_data !== 8'h0A) begin
      errors++;
      $display("FAIL srl_latency: vld=%0b data=%02h expected 1/0a", res_valid, res_data);
    end
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL srl_release: vld=%0b rdy=%0b expected 0/1", res_valid, req_ready);
    end
    wait_drain();
  endtask

  task automatic test_sra();
    res_ready = 1'b1;
    issue(2'b10, 8'd9, 8'h91);
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL sra_two_pass: vld=%0b after first pass expected 0", res_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b1 || res_data !== 8'hFF) begin
      errors++;
      $display("FAIL sra_sat_neg: vld=%0b data=%02h expected 1/ff", res_valid, res_data);
    end
    wait_drain();
    issue(2'b10, 8'd200, 8'h71);
    wait_drain();
  endtask

  task automatic test_ror_sll();
    res_ready = 1'b1;
    issue(2'b11, 8'd11, 8'h51);
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b1 || res_data !== 8'h2A) begin
      errors++;
      $display("FAIL ror_one_pass: vld=%0b data=%02h expected 1/2a", res_valid, res_data);
    end
    wait_drain();
    issue(2'b00, 8'd2, 8'h51);
    wait_drain();
    issue(2'b00, 8'd8, 8'hFF);
    wait_drain();
  endtask

  task automatic test_backpressure();
    res_ready = 1'b0;
    issue(2'b01, 8'd0, 8'hA5);
    @(posedge clk); #1;
    req_op = 2'b01; req_amt = 8'd4; req_data = 8'hF0; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (res_valid !== 1'b1 || res_data !== 8'hA5 || req_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: vld=%0b data=%02h rdy=%0b busy=%0b expected 1/a5/0/1",
                 i, res_valid, res_data, req_ready, busy);
      end
      @(posedge clk); #1;
    end
    // Release with a request still pending: it must not enter on the consume edge.
    exp_q.push_back(model(2'b01, 8'd4, 8'hF0));
    res_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL consume_no_accept: vld=%0b busy=%0b rdy=%0b expected 0/0/1",
               res_valid, busy, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL accept_after_consume: busy=%0b expected 1", busy);
    end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    res_ready = 1'b1;
    issue(2'b00, 8'd8, 8'hFF);
    void'(exp_q.pop_back());    // this result is discarded by reset
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({req_ready, res_valid, busy, res_data} !== 11'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs: rdy=%0b vld=%0b busy=%0b data=%02h expected all 0",
               req_ready, res_valid, busy, res_data);
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (res_valid) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_no_result: vld_cycles=%0d rdy=%0b expected 0/1", seen, req_ready);
    end
    issue(2'b01, 8'd7, 8'h80);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int target;
    int n;
    target = popped + 20;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          logic [7:0] a;
          a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
          issue(2'($urandom_range(0, 3)), a, 8'($urandom_range(0, 255)));
        end
      end
      begin
        n = 0;
        while (popped < target && n < 2000) begin
          @(posedge clk); #1;
          res_ready = ($urandom_range(0, 2) != 0);
          n++;
        end
      end
    join
    res_ready = 1'b1;
    checks++;
    if (popped != target || exp_q.size() != 0) begin
      errors++;
      $display("FAIL back_to_back_count: consumed=%0d pending=%0d expected %0d/0",
               popped - (target - 20), exp_q.size(), 20);
    end
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_srl();
    test_sra();
    test_ror_sll();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Sequencing controller for the 8-bit right barrel shifter core in the ALU. It accepts one shift/rotate request through a valid/ready handshake and normalises the shift amount. It then drives the 3-bit-amount core for one or two passes, building left shifts by bit reversal and amounts of 8 or more from chained passes. The result is held in a registered output until the consumer takes it. It sits between the instruction decode/ALU issue logic and the register-file write-back path.

## Interface
- DATA_W, 8, datapath width; only 8 is supported.
- MAX_STEP, 7, largest amount the core applies in one pass.
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-low reset; the block is in reset while RESET=0 at a rising edge.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  block can accept a request; high only in IDLE.
- REQ_OP  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- REQ_AMT  in  8  unsigned shift amount.
- REQ_DATA  in  8  operand.
- RES_VALID  out  1  result available.
- RES_READY  in  1  consumer takes the result.
- RES_DATA  out  8  result; stable while RES_VALID=1.
- BUSY  out  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- Transitions:
  - IDLE to RUN on REQ_VALID & REQ_READY.
  - RUN to RUN while remaining amount is greater than 0 after the current pass.
  - RUN to DONE when the remaining amount is 0 after the current pass.
  - DONE to IDLE on RES_READY.
- Capture on accept: op, working register W <= REQ_DATA, and remaining count R <= effective amount. For SLL, W is loaded bit-reversed.
- Effective amount:
  - ROR: REQ_AMT[2:0].
  - SLL, SRL, SRA: min(REQ_AMT, 8).
- Each RUN cycle:
  - step = min(R, MAX_STEP).
  - W <= core(W, step), where the core is configured as arithmetic fill for SRA, rotate for ROR, and zero fill otherwise.
  - R <= R − step.
- Amount 0 still takes one pass with step 0, so W passes through unchanged.
- On entering DONE, RES_DATA <= W, bit-reversed back for SLL.
- Saturation: SRL/SLL by 8 or more gives 0x00. SRA by 8 or more gives 0x00 or 0xFF according to the operand MSB.
- Request inputs are ignored outside IDLE. No request is accepted in the same cycle that a result is consumed.

## Timing
- Reset values:
  - REQ_READY=0 during reset, 1 on the first cycle after release.
  - RES_VALID=0, RES_DATA=0x00, BUSY=0, state=IDLE, W=0, R=0.
- Latency: if acceptance happens at edge t0, RES_VALID rises after edge t0+k. k=1 for effective amounts 0–7 and k=2 for an effective amount of 8.
- RES_VALID and RES_DATA hold until an edge with RES_READY=1. RES_VALID drops after that edge and REQ_READY rises after the same edge.
- Throughput: one request per k+2 cycles at best.
- Reset mid-operation: if RESET=0 at any edge in RUN or DONE, the block returns to IDLE with the reset values above. The pending result is discarded and RES_VALID is never asserted for it.
- RES_READY asserted before DONE has no effect.

## Structure
- Shared package `shift_pkg`:
  - op-code constants OP_SLL/OP_SRL/OP_SRA/OP_ROR;
  - state encoding ST_IDLE/ST_RUN/ST_DONE;
  - MAX_STEP.
- One sub-module, `shift_core8`: a combinational 3-stage (1/2/4) right shifter with inputs ARITH, ROT, AMT[2:0], DATA[7:0] and output OUT[7:0], using zero, sign or rotate fill.
- Bit reversal, amount normalisation, FSM and output register live in shift_seq_ctrl.

## Test plan
- SRL, data 0x51, amt 3, RES_READY=1 → RES_DATA=0x0A, RES_VALID 1 cycle after accept, REQ_READY high the following cycle.
- SRA, data 0x91, amt 9 → two RUN cycles (step 7 then 1), RES_DATA=0xFF. SRA with data 0x71, amt 200 → 0x00.
- ROR, data 0x51, amt 11 → effective 3, one pass, RES_DATA=0x2A. SLL, data 0x51, amt 2 → 0x44.
- Backpressure: SRL, data 0xA5, amt 0, RES_READY=0 for 3 cycles → RES_DATA=0xA5 held stable with RES_VALID=1 and REQ_READY=0; a second REQ_VALID during that time is not accepted. Released when RES_READY=1.
- Reset: assert RESET=0 during the RUN cycle of an amt-8 SLL → next cycle all outputs at reset values, RES_VALID never pulses. After release, a fresh SRL with data 0x80, amt 7 returns 0x01.
- Back-to-back: 20 random requests with random RES_READY stalls, compared against a reference model → all results match, no request lost or duplicated.
